spike_aer_encoder: RTL and testbench

- Downstream stage of the time-multiplexed LIF neuron array.
- Captures the 8-bit spike vector once per time step and serialises each set bit into an address-event (AER) word: {timestamp, neuron address}.
- Events pass through a small FIFO and leave on a valid/ready interface toward the router/output pins.
- Flags and counts spikes it has to drop.

---
 rtl/spike_aer_encoder.sv | 82 ++++++++
 tb/tb_spike_aer_encoder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: serialises per-time-step spike vectors into {timestamp, address} AER events through a FWFT FIFO
module spike_aer_encoder #(
  parameter int N_NEURONS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = 5,
  localparam int ADDR_W    = $clog2(N_NEURONS),
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1),
  localparam int DATA_W    = TS_W + ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_NEURONS-1:0] spike_in,
  input  logic                 spike_valid,
  input  logic                 aer_ready,
  output logic                 aer_valid,
  output logic [DATA_W-1:0]    aer_data,
  output logic [CNT_W-1:0]     fifo_count,
  output logic                 overflow,
  output logic [7:0]           drop_cnt
);
  logic [TS_W-1:0]      ts_ctr, pending_ts;
  logic [N_NEURONS-1:0] pending, pending_next;
  logic [ADDR_W-1:0]    low_idx;
  logic [ADDR_W:0]      spike_pop;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0]    mem [FIFO_DEPTH];
  logic [8:0]           drop_sum;
  logic                 pop, push, accept;

  assign aer_valid    = fifo_count != '0;
  assign aer_data     = aer_valid ? mem[rd_ptr] : '0;
  assign pop          = aer_valid && aer_ready;
  assign push         = (pending != '0) && ((fifo_count < CNT_W'(FIFO_DEPTH)) || pop);
  assign pending_next = push ? pending & ~(N_NEURONS'(1) << low_idx) : pending;
  assign accept       = spike_valid && (pending_next == '0);
  assign drop_sum     = {1'b0, drop_cnt} + 9'(spike_pop);

  // lowest set bit of pending is the next address to emit
  always_comb begin
    low_idx = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--)
      if (pending[i]) low_idx = ADDR_W'(i);
  end

  // number of spikes lost when a whole vector is rejected
  always_comb begin
    spike_pop = '0;
    for (int i = 0; i < N_NEURONS; i++)
      spike_pop = spike_pop + (ADDR_W + 1)'(spike_in[i]);
  end

  // capture, drain, drop accounting and FIFO bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_ctr     <= '0;
      pending    <= '0;
      pending_ts <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (spike_valid) ts_ctr <= ts_ctr + 1'b1;
      pending <= accept ? spike_in : pending_next;
      if (accept) pending_ts <= ts_ctr;
      if (spike_valid && !accept) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum > 9'd255 ? 8'd255 : drop_sum[7:0];
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // event storage; contents are masked while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pending_ts, low_idx};
  end
endmodule

// File: tb/tb_spike_aer_encoder.sv
// tb_spike_aer_encoder: directed vector table plus hand sequences for full/drop/wrap/reset cases
module tb_spike_aer_encoder;
  logic       clk = 0, rst_n = 0, spike_valid = 0, aer_ready = 0;
  logic [7:0] spike_in = '0;
  logic       aer_valid, overflow;
  logic [7:0] aer_data, drop_cnt;
  logic [3:0] fifo_count;
  int         errors = 0, checks = 0;

  spike_aer_encoder dut (
    .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .spike_valid(spike_valid),
    .aer_ready(aer_ready), .aer_valid(aer_valid), .aer_data(aer_data),
    .fifo_count(fifo_count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       sv;
    logic [7:0] si;
    logic       rdy;
    logic       valid;
    logic [7:0] data;
    logic [3:0] cnt;
    logic       ovf;
    logic [7:0] drop;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [7:0] d,
                         input logic [3:0] c, input logic o, input logic [7:0] dr);
    chk({tag, ".valid"}, int'(aer_valid), int'(v));
    chk({tag, ".data"}, int'(aer_data), int'(d));
    chk({tag, ".count"}, int'(fifo_count), int'(c));
    chk({tag, ".ovf"}, int'(overflow), int'(o));
    chk({tag, ".drop"}, int'(drop_cnt), int'(dr));
  endtask

  task automatic do_reset();
    rst_n = 0; spike_valid = 0; spike_in = '0; aer_ready = 0;
    step();
    rst_n = 1;
  endtask

  initial begin
    // rst, sv, si, rdy | valid, data, count, ovf, drop
    tv.push_back('{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0});
    tv.push_back('{1, 1, 8'h05, 1, 0, 8'h00, 0, 0, 0});
    tv.push_back('{1, 0, 8'h00, 1, 1, 8'h00, 1, 0, 0});
    tv.push_back('{1, 0, 8'h00, 1, 1, 8'h02, 1, 0, 0});
    tv.push_back('{1, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0});
    tv.push_back('{0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0});
    tv.push_back('{1, 1, 8'h00, 1, 0, 8'h00, 0, 0, 0});
    tv.push_back('{1, 1, 8'h00, 1, 0, 8'h00, 0, 0, 0});
    tv.push_back('{1, 1, 8'h00, 1, 0, 8'h00, 0, 0, 0});
    tv.push_back('{1, 1, 8'h00, 1, 0, 8'h00, 0, 0, 0});
    tv.push_back('{1, 1, 8'h80, 1, 0, 8'h00, 0, 0, 0});
    tv.push_back('{1, 0, 8'h00, 1, 1, 8'h27, 1, 0, 0});
    tv.push_back('{1, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0});

    step();
    foreach (tv[i]) begin
      rst_n = tv[i].rst_n; spike_valid = tv[i].sv; spike_in = tv[i].si; aer_ready = tv[i].rdy;
      step();
      chk_all($sformatf("vec%0d", i), tv[i].valid, tv[i].data, tv[i].cnt, tv[i].ovf, tv[i].drop);
    end

    // fill FIFO while stalled, two vectors rejected during the drain
    do_reset();
    spike_valid = 1; spike_in = 8'hFF; step();
    spike_in = 8'h01; step();
    spike_valid = 0; step();
    spike_valid = 1; step();
    spike_valid = 0; spike_in = '0;
    repeat (7) step();
    chk_all("full", 1, 8'h00, 8, 1, 2);
    spike_valid = 1; spike_in = 8'h01; step();
    spike_valid = 0; spike_in = '0; step();
    chk_all("full_hold", 1, 8'h00, 8, 1, 2);
    aer_ready = 1; step();
    aer_ready = 0;
    chk_all("pop_push", 1, 8'h01, 8, 1, 2);
    aer_ready = 1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d", k), int'(aer_data), k < 7 ? k + 1 : 8'h18);
      step();
    end
    chk("drain_empty", int'(fifo_count), 0);

    // timestamp wrap over 33 steps
    do_reset();
    aer_ready = 1;
    for (int i = 0; i < 33; i++) begin
      spike_valid = 1; spike_in = 8'h01; step();
      spike_valid = 0; spike_in = '0; step();
      if (i < 2 || i > 29) chk_all($sformatf("wrap%0d", i), 1, 8'((i % 32) << 3), 1, 0, 0);
      else chk($sformatf("wrap%0d", i), int'(aer_data), (i % 32) << 3);
      step();
    end
    chk("wrap_empty", int'(aer_valid), 0);

    // asynchronous reset mid-drain
    do_reset();
    spike_valid = 1; spike_in = 8'hFF; step();
    spike_in = 8'h01; step();
    spike_valid = 0; spike_in = '0;
    repeat (4) step();
    chk_all("pre_rst", 1, 8'h00, 5, 1, 1);
    rst_n = 0;
    #1;
    chk_all("async_rst", 0, 8'h00, 0, 0, 0);
    step();
    rst_n = 1; aer_ready = 1; spike_valid = 1; spike_in = 8'h04; step();
    spike_valid = 0; spike_in = '0; step();
    chk_all("post_rst", 1, 8'h02, 1, 0, 0);
    step();
    chk("post_rst_empty", int'(fifo_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
